// File: rtl/spart_driver.sv
// spart_driver: bus master that programs the SPART baud divisor, then echoes
// received bytes back through a 4-deep FIFO.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   br_cfg[1:0]   baud select (00=4800 01=9600 10=19200 11=38400)
//   rda, tbr      SPART receive-available / transmit-ready
//   iocs, iorw    chip select; 1=read 0=write
//   ioaddr[1:0]   00=data 01=status 10=div lo 11=div hi
//   databus[7:0]  driven only while iocs=1 and iorw=0
//   fifo_cnt[2:0] echo FIFO occupancy (0..4)
//   cfg_done      high once the divisor is programmed
//
// Optional feature macro: SPART_DRIVER_RECFG_EN
//   defined   : br_cfg is rechecked in every IDLE cycle and a change
//               reprograms the divisor (FIFO contents kept)
//   undefined : br_cfg is sampled only right after reset
module spart_driver #(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [2:0] fifo_cnt,
  output logic       cfg_done
);

  // Rounded divisor; at 100 MHz this gives 0x0515, 0x028A, 0x0145, 0x00A2.
  function automatic logic [15:0] div_for(input int unsigned baud);
    return 16'((CLK_HZ + 8 * baud) / (16 * baud) - 1);
  endfunction

  localparam logic [15:0] DIV0 = div_for(4800);
  localparam logic [15:0] DIV1 = div_for(9600);
  localparam logic [15:0] DIV2 = div_for(19200);
  localparam logic [15:0] DIV3 = div_for(38400);

  typedef enum logic [2:0] {
    S_CFG_LO,
    S_CFG_HI,
    S_IDLE,
    S_RD,
    S_WR,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic        ph_q, ph_d;
  logic        gap_hi_q, gap_hi_d;
  logic        first_q;
  logic [1:0]  cfg_q;
  logic        cfg_done_q;
  logic [7:0]  mem [4];
  logic [1:0]  wptr_q, rptr_q;
  logic [2:0]  cnt_q;

  logic        push, pop;
  logic        cfg_ld;
  logic        done_set, done_clr;
  logic        recfg;
  logic        bus_on, bus_wr;
  logic [1:0]  addr;
  logic [7:0]  dout;
  logic [1:0]  cfg_sel;
  logic [15:0] div_sel;
  logic        drive;

  // During the very first cycle after reset the register is still loading,
  // so the live switch value feeds the divisor directly.
  assign cfg_sel = first_q ? br_cfg : cfg_q;

  always_comb begin
    div_sel = DIV0;
    unique case (cfg_sel)
      2'b00: div_sel = DIV0;
      2'b01: div_sel = DIV1;
      2'b10: div_sel = DIV2;
      2'b11: div_sel = DIV3;
      default: div_sel = DIV0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = 1'b0;
    gap_hi_d = gap_hi_q;
    push     = 1'b0;
    pop      = 1'b0;
    cfg_ld   = 1'b0;
    done_set = 1'b0;
    done_clr = 1'b0;
    recfg    = 1'b0;
    bus_on   = 1'b0;
    bus_wr   = 1'b0;
    addr     = 2'b00;
    dout     = 8'h00;
    unique case (state_q)
      S_CFG_LO: begin
        bus_on = 1'b1;
        bus_wr = 1'b1;
        addr   = 2'b10;
        dout   = div_sel[7:0];
        if (ph_q) begin
          state_d  = S_GAP;
          gap_hi_d = 1'b1;
        end else begin
          ph_d = 1'b1;
        end
      end
      S_CFG_HI: begin
        bus_on = 1'b1;
        bus_wr = 1'b1;
        addr   = 2'b11;
        dout   = div_sel[15:8];
        if (ph_q) begin
          state_d  = S_GAP;
          gap_hi_d = 1'b0;
          done_set = 1'b1;
        end else begin
          ph_d = 1'b1;
        end
      end
      S_IDLE: begin
`ifdef SPART_DRIVER_RECFG_EN
        recfg = (br_cfg != cfg_q);
`endif
        // Reads win over writes so the SPART receiver cannot overrun.
        if (recfg) begin
          state_d  = S_CFG_LO;
          cfg_ld   = 1'b1;
          done_clr = 1'b1;
        end else if (rda && cnt_q != 3'd4) begin
          state_d = S_RD;
        end else if (tbr && cnt_q != 3'd0) begin
          state_d = S_WR;
        end
      end
      S_RD: begin
        bus_on = 1'b1;
        if (ph_q) begin
          push    = 1'b1;
          state_d = S_GAP;
        end else begin
          ph_d = 1'b1;
        end
      end
      S_WR: begin
        bus_on = 1'b1;
        bus_wr = 1'b1;
        dout   = mem[rptr_q];
        if (ph_q) begin
          pop     = 1'b1;
          state_d = S_GAP;
        end else begin
          ph_d = 1'b1;
        end
      end
      S_GAP: begin
        state_d = gap_hi_q ? S_CFG_HI : S_IDLE;
      end
      default: begin
        state_d = S_CFG_LO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CFG_LO;
      ph_q       <= 1'b0;
      gap_hi_q   <= 1'b0;
      first_q    <= 1'b1;
      cfg_q      <= br_cfg;
      cfg_done_q <= 1'b0;
      wptr_q     <= 2'd0;
      rptr_q     <= 2'd0;
      cnt_q      <= 3'd0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      gap_hi_q <= gap_hi_d;
      first_q  <= 1'b0;
      if (first_q || cfg_ld) begin
        cfg_q <= br_cfg;
      end
      if (done_set) begin
        cfg_done_q <= 1'b1;
      end else if (done_clr) begin
        cfg_done_q <= 1'b0;
      end
      if (push) begin
        wptr_q <= wptr_q + 2'd1;
        cnt_q  <= cnt_q + 3'd1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 2'd1;
        cnt_q  <= cnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wptr_q] <= databus;
    end
  end

  // Reset blanks the bus immediately so an interrupted transaction
  // never leaves a stale drive on the SPART.
  assign iocs     = bus_on & ~rst;
  assign iorw     = ~(bus_wr & ~rst);
  assign ioaddr   = rst ? 2'b00 : addr;
  assign drive    = iocs & ~iorw;
  assign databus  = drive ? dout : 8'hzz;
  assign fifo_cnt = cnt_q;
  assign cfg_done = cfg_done_q;

endmodule
